// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions.
//   - icode constants IHALT..IPOPQ (0..11)
//   - mem_state_t: state encoding of the memory-stage access FSM
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/dmem_bytes.sv
// Byte-wide data RAM used by the memory stage.
// Ports:
//   clock   - rising-edge clock
//   addr    - byte address (AW bits)
//   wr_en   - write enable; wr_data is stored at addr on the clock edge
//   wr_data - byte to write
//   rd_data - combinational read of the byte at addr
// Contents are not reset.
module dmem_bytes #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage. Performs the single 8-byte data access of the
// current instruction through a byte-wide RAM, one byte per cycle.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   start               - request, sampled only in IDLE
//   in_code             - icode of the instruction
//   val_e, val_a, val_p - execute result, register A value, next PC
//   busy                - high whenever the FSM is not IDLE
//   done                - one-cycle completion pulse
//   val_m               - little-endian read data (0 for writes/non-access/fault)
//   dmem_error          - address fault of the completed operation
//   state_dbg           - current FSM state, for observation
//
// Handshake: a request is taken on any rising edge where state is IDLE and
// start=1 (reset wins). busy rises after that edge and stays high until the
// edge that leaves DONE; done is high for exactly the one DONE cycle, and
// val_m/dmem_error are valid then and held until the next DONE. start
// while busy is dropped, not queued.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic [63:0] val_e,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    output logic        busy,
    output logic        done,
    output logic [63:0] val_m,
    output logic        dmem_error,
    output mem_state_t  state_dbg
);

    localparam int AW = (MEM_BYTES > 8) ? $clog2(MEM_BYTES) : 3;
    // Highest legal base address. The unsigned compare against this also
    // rejects addresses where addr+7 would wrap past 2^64.
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    mem_state_t state, state_next;

    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   data_q;   // write data shifts out / read data shifts in
    logic [2:0]    cnt;

    logic          req_access;
    logic          req_write;
    logic [63:0]   req_addr;
    logic [63:0]   req_wdata;
    logic          addr_ok;

    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;
    logic [7:0]    ram_rd_data;

    // Decode of the incoming request.
    always_comb begin
        req_access = 1'b0;
        req_write  = 1'b0;
        req_addr   = val_e;
        req_wdata  = val_a;
        case (in_code)
            IRMMOVQ: begin req_access = 1'b1; req_write = 1'b1; end
            IMRMOVQ: begin req_access = 1'b1; end
            ICALL:   begin req_access = 1'b1; req_write = 1'b1; req_wdata = val_p; end
            IRET:    begin req_access = 1'b1; req_addr = val_a; end
            IPUSHQ:  begin req_access = 1'b1; req_write = 1'b1; end
            IPOPQ:   begin req_access = 1'b1; req_addr = val_a; end
            default: ;
        endcase
    end

    assign addr_ok = (req_addr <= ADDR_MAX);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (req_access && addr_ok) ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (cnt == 3'd7) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: request latch, byte counter, shift/assemble register, results.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt        <= '0;
            val_m      <= '0;
            dmem_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        write_q <= req_write;
                        addr_q  <= req_addr[AW-1:0];
                        data_q  <= req_wdata;
                        cnt     <= '0;
                        // Short path: results are final right away.
                        if (!(req_access && addr_ok)) begin
                            val_m      <= '0;
                            dmem_error <= req_access;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 3'd1;
                    // Writes consume the low byte; reads push the new byte in
                    // at the top so byte 0 ends up in bits [7:0].
                    if (write_q) begin
                        data_q <= data_q >> 8;
                    end else begin
                        data_q <= {ram_rd_data, data_q[63:8]};
                    end
                    if (cnt == 3'd7) begin
                        val_m      <= write_q ? 64'd0 : {ram_rd_data, data_q[63:8]};
                        dmem_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = addr_q + AW'(cnt);
    // Reset blocks the write on its own edge so an aborted transfer stops
    // at exactly the bytes already committed.
    assign ram_wr_en = (state == ST_ACCESS) && write_q && !reset;

    dmem_bytes #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_dmem (
        .clock   (clock),
        .addr    (ram_addr),
        .wr_en   (ram_wr_en),
        .wr_data (data_q[7:0]),
        .rd_data (ram_rd_data)
    );

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    import y86_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  in_code = 4'd0;
    logic [63:0] val_e = 64'd0;
    logic [63:0] val_a = 64'd0;
    logic [63:0] val_p = 64'd0;
    logic        busy;
    logic        done;
    logic [63:0] val_m;
    logic        dmem_error;
    mem_state_t  state_dbg;

    always #5 clock = ~clock;

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_code    (in_code),
        .val_e      (val_e),
        .val_a      (val_a),
        .val_p      (val_p),
        .busy       (busy),
        .done       (done),
        .val_m      (val_m),
        .dmem_error (dmem_error),
        .state_dbg  (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [64:0] exp_q[$];   // {dmem_error, val_m}
    logic [64:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("val_m", val_m, mon_e[63:0]);
                check("dmem_error", {63'd0, dmem_error}, {63'd0, mon_e[64]});
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge while idle; returns at a negedge while idle.
    task automatic run_op(input logic [3:0] icode, input logic [63:0] ve,
                          input logic [63:0] va, input logic [63:0] vp,
                          input logic [63:0] exp_vm, input logic exp_err,
                          input int exp_lat);
        int lat;
        in_code = icode;
        val_e   = ve;
        val_a   = va;
        val_p   = vp;
        start   = 1'b1;
        exp_q.push_back({exp_err, exp_vm});
        @(posedge clock);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (lat == 0) exp_q.delete();
        @(negedge clock);
        check("idle_after", {63'd0, busy}, 64'd0);
        check("val_m_hold", val_m, exp_vm);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]  icode;
        logic [63:0] ve;
        logic [63:0] va;
        logic [63:0] vp;
        logic [63:0] exp_vm;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int dc0;
        logic [63:0] r_addr;
        logic [63:0] r_data;

        vecs[0]  = '{IRMMOVQ, 64'h10, 64'h1122334455667788, 64'h0, 64'h0, 1'b0, 9};
        vecs[1]  = '{IMRMOVQ, 64'h10, 64'h5555, 64'h0, 64'h1122334455667788, 1'b0, 9};
        vecs[2]  = '{ICALL,   64'h3F8, 64'h5555, 64'h2A, 64'h0, 1'b0, 9};
        vecs[3]  = '{IRET,    64'hFFFF_FFFF, 64'h3F8, 64'h0, 64'h2A, 1'b0, 9};
        vecs[4]  = '{IMRMOVQ, 64'h3F9, 64'h0, 64'h0, 64'h0, 1'b1, 1};
        vecs[5]  = '{IMRMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 1'b1, 1};
        vecs[6]  = '{IRMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1};
        vecs[7]  = '{IRMMOVQ, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1};
        vecs[8]  = '{IMRMOVQ, 64'h3F8, 64'h0, 64'h0, 64'h2A, 1'b0, 9};
        vecs[9]  = '{IOPQ,    64'h3F9, 64'h0, 64'h0, 64'h0, 1'b0, 1};
        vecs[10] = '{IPUSHQ,  64'h3F0, 64'hDEADBEEFCAFEF00D, 64'h77, 64'h0, 1'b0, 9};
        vecs[11] = '{IPOPQ,   64'hFFFF_0000, 64'h3F0, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9};
        vecs[12] = '{IHALT,   64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1};
        vecs[13] = '{IMRMOVQ, 64'h400, 64'h0, 64'h0, 64'h0, 1'b1, 1};

        // reset state
        repeat (2) @(negedge clock);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_val_m", val_m, 64'd0);
        check("rst_err", {63'd0, dmem_error}, 64'd0);
        check("rst_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
        reset = 1'b0;
        @(negedge clock);

        // table
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].icode, vecs[i].ve, vecs[i].va, vecs[i].vp,
                   vecs[i].exp_vm, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // random write/read-back pairs
        for (int i = 0; i < 4; i++) begin
            r_addr = 64'($urandom_range(32'h100 + 32'(i) * 32'h40, 32'h100 + 32'(i) * 32'h40 + 32'h30));
            r_data = {$urandom, $urandom};
            run_op(IRMMOVQ, r_addr, r_data, 64'h0, 64'h0, 1'b0, 9);
            run_op(IMRMOVQ, r_addr, 64'h0, 64'h0, r_data, 1'b0, 9);
        end

        // start pulsed during a busy access is ignored
        dc0 = done_count;
        in_code = IRMMOVQ; val_e = 64'h20; val_a = 64'hA5A5_0102_0304_5A5A; start = 1'b1;
        exp_q.push_back({1'b0, 64'h0});
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        in_code = IOPQ; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        @(posedge clock);
        check("one_done", 64'(done_count - dc0), 64'd1);
        @(negedge clock);
        run_op(IMRMOVQ, 64'h20, 64'h0, 64'h0, 64'hA5A5_0102_0304_5A5A, 1'b0, 9);

        // reset in the middle of a pushq
        run_op(IRMMOVQ, 64'h40, 64'h0807060504030201, 64'h0, 64'h0, 1'b0, 9);
        run_op(IMRMOVQ, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 1'b0, 9);
        dc0 = done_count;
        in_code = IPUSHQ; val_e = 64'h40; val_a = 64'hF1F2F3F4F5F6F7F8; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_val_m", val_m, 64'd0);
        check("abort_err", {63'd0, dmem_error}, 64'd0);
        check("abort_state", {62'd0, state_dbg}, {62'd0, ST_IDLE});
        reset = 1'b0;
        repeat (12) @(negedge clock);
        @(posedge clock);
        check("abort_no_done", 64'(done_count - dc0), 64'd0);
        @(negedge clock);
        run_op(IMRMOVQ, 64'h40, 64'h0, 64'h0, 64'h0807060504F6F7F8, 1'b0, 9);

        // reset and start on the same edge
        dc0 = done_count;
        reset = 1'b1; start = 1'b1; in_code = IOPQ;
        @(negedge clock);
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        check("rst_start_no_done", 64'(done_count - dc0), 64'd0);
        @(negedge clock);

        if (exp_q.size() != 0) check("pending_expected", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
